sign_to_fingers: RTL and testbench
==================================

Name: sign_to_fingers

Overview:
Takes a 4-bit sign code and reproduces it as the five finger-status lines that a correct sign-identification stage would decode back to the same code. Used as a gesture playback source (finger actuator drive or loop-back stimulus) beside the sign-identification path. One sign is accepted per valid/ready handshake. The finger pattern is held for a programmable time, then the lines return to rest and a programmable gap follows before the next sign is accepted.

Parameters:
HOLD_CYCLES, 16, number of cycles the sign pattern is driven (legal range ≥1)
GAP_CYCLES, 4, number of rest cycles after the hold (0 allowed: the gap is skipped)
CNT_W, 8, counter width; must satisfy HOLD_CYCLES, GAP_CYCLES ≤ 2^CNT_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
sign_valid  in  1  sign_value is offered
sign_ready  out  1  block can accept a sign
sign_value  in  4  sign code to play
abort  in  1  synchronous cancel of the sign in progress
thumb_status  out  1  finger line, 1 = raised
index_status  out  1  finger line
middle_status  out  1  finger line
ring_status  out  1  finger line
pinky_status  out  1  finger line
busy  out  1  high in HOLD and GAP
done  out  1  one-cycle pulse when a played sign completes
sign_err  out  1  one-cycle pulse when an undefined code is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - All finger lines 0; busy=0, done=0, sign_err=0.
  - sign_ready=1 once rst is released.
- Pattern P = {thumb,index,middle,ring,pinky}:
  - 0 → 00000
  - 1 → 01000
  - 2 → 01100
  - 3 → 01110
  - 4 → 01111
  - 5 → 11111
  - 6 → 10000
  - 7 → 10001
  - 8 → 01001
  - 9 → 11000
  - 10–15 are undefined.
- sign_ready = (state==IDLE), decoded from the state register. Transfer occurs on the edge where sign_valid & sign_ready.
- IDLE:
  - All finger lines are 0 (rest).
  - Transfer with a defined code: on the next cycle the finger lines show P, state=HOLD, counter=HOLD_CYCLES-1.
  - Transfer with an undefined code: the code is consumed, sign_err=1 for exactly one cycle, state stays IDLE, lines stay 0, no done.
- HOLD:
  - Lines are held at P; the counter decrements each cycle.
  - At counter==0:
    - If GAP_CYCLES>0: lines go to 0 on the next cycle, state=GAP, counter=GAP_CYCLES-1.
    - If GAP_CYCLES==0: lines go to 0, state=IDLE, done=1 on the same next cycle.
  - The pattern is visible for exactly HOLD_CYCLES cycles.
- GAP:
  - Lines are 0. At counter==0: state=IDLE and done=1 on the next cycle.
  - sign_ready is high in that same cycle, so back-to-back signs are allowed.
- Total occupancy per defined sign = HOLD_CYCLES + GAP_CYCLES cycles, plus one IDLE accept cycle.
- abort:
  - In HOLD or GAP, abort=1 → next cycle: lines 0, state=IDLE, counter=0, no done.
  - In IDLE, abort has priority over a simultaneous transfer: no transfer occurs, and sign_ready is still 1 that cycle, so the producer must hold sign_valid.
  - The handshake is therefore defined as sign_valid & sign_ready & ~abort.
- sign_value is ignored outside a transfer. Changing it during HOLD does not alter the outputs.
- All outputs except sign_ready are registered.
- Reset asserted mid-HOLD or mid-GAP returns everything to reset values immediately, with no done.

Decomposition:
- Shared package:
  - Sign code constants SIGN_FIST … SIGN_THUMB_INDEX (0–9).
  - 5-bit finger pattern constants.
  - State enum IDLE/HOLD/GAP.
  - Function sign_to_pattern(code) returning {valid, pattern[4:0]}, so the sign-identification side can reuse the same table.
- Sub-module hold_timer (loadable down-counter with a zero flag) is natural; the FSM and output register stay in sign_to_fingers.

Test Plan:
- Reset then release, sign_valid=0 → lines 00000, sign_ready=1, busy=0; assert rst low mid-HOLD → immediate return to reset values.
- Send code 3 (HOLD=16, GAP=4) → lines 01110 for exactly 16 cycles starting the cycle after the transfer, then 00000 for 4 cycles, done pulse 1 cycle, sign_ready=1 that cycle.
- Send code 12 → sign_err one-cycle pulse, lines stay 00000, no done, sign_ready stays 1; then send code 5 → lines 11111.
- Back-to-back: sign_valid held high with codes 7 then 8 → 10001 for 16 cycles, 4 gap cycles, 01001 begins on the cycle after done; no idle cycle lost.
- abort in HOLD cycle 5 of code 9 → lines 00000 next cycle, no done; abort coincident with an IDLE transfer → no transfer, busy stays 0.
- Build with GAP_CYCLES=0, HOLD_CYCLES=1, code 2 → 01100 for one cycle, then 00000 with done in the same cycle.

Source files
------------

// File: rtl/sign_to_fingers_pkg.sv
// Shared sign-code table: code constants, finger patterns, playback states and
// the code-to-pattern lookup also used by the sign-identification side.
package sign_to_fingers_pkg;

  localparam logic [3:0] SIGN_FIST         = 4'd0;
  localparam logic [3:0] SIGN_ONE          = 4'd1;
  localparam logic [3:0] SIGN_TWO          = 4'd2;
  localparam logic [3:0] SIGN_THREE        = 4'd3;
  localparam logic [3:0] SIGN_FOUR         = 4'd4;
  localparam logic [3:0] SIGN_OPEN         = 4'd5;
  localparam logic [3:0] SIGN_THUMB        = 4'd6;
  localparam logic [3:0] SIGN_THUMB_PINKY  = 4'd7;
  localparam logic [3:0] SIGN_INDEX_PINKY  = 4'd8;
  localparam logic [3:0] SIGN_THUMB_INDEX  = 4'd9;

  // Bit order {thumb, index, middle, ring, pinky}, 1 = raised.
  localparam logic [4:0] PAT_FIST         = 5'b00000;
  localparam logic [4:0] PAT_ONE          = 5'b01000;
  localparam logic [4:0] PAT_TWO          = 5'b01100;
  localparam logic [4:0] PAT_THREE        = 5'b01110;
  localparam logic [4:0] PAT_FOUR         = 5'b01111;
  localparam logic [4:0] PAT_OPEN         = 5'b11111;
  localparam logic [4:0] PAT_THUMB        = 5'b10000;
  localparam logic [4:0] PAT_THUMB_PINKY  = 5'b10001;
  localparam logic [4:0] PAT_INDEX_PINKY  = 5'b01001;
  localparam logic [4:0] PAT_THUMB_INDEX  = 5'b11000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Returns {defined, pattern}; undefined codes give {0, 00000}.
  function automatic logic [5:0] sign_to_pattern(input logic [3:0] code);
    logic [5:0] r;
    case (code)
      SIGN_FIST:        r = {1'b1, PAT_FIST};
      SIGN_ONE:         r = {1'b1, PAT_ONE};
      SIGN_TWO:         r = {1'b1, PAT_TWO};
      SIGN_THREE:       r = {1'b1, PAT_THREE};
      SIGN_FOUR:        r = {1'b1, PAT_FOUR};
      SIGN_OPEN:        r = {1'b1, PAT_OPEN};
      SIGN_THUMB:       r = {1'b1, PAT_THUMB};
      SIGN_THUMB_PINKY: r = {1'b1, PAT_THUMB_PINKY};
      SIGN_INDEX_PINKY: r = {1'b1, PAT_INDEX_PINKY};
      SIGN_THUMB_INDEX: r = {1'b1, PAT_THUMB_INDEX};
      default:          r = 6'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sign_to_fingers_hold_timer.sv
// Loadable down-counter with a zero flag; stops at zero, clear wins over load.
module hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sign_to_fingers.sv
// Plays a 4-bit sign code as five finger lines: hold the pattern, rest for a
// gap, then accept the next sign. Handshake notes are on the xfer assign.
module sign_to_fingers
  import sign_to_fingers_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sign_valid,
  output logic       sign_ready,
  input  logic [3:0] sign_value,
  input  logic       abort,
  output logic       thumb_status,
  output logic       index_status,
  output logic       middle_status,
  output logic       ring_status,
  output logic       pinky_status,
  output logic       busy,
  output logic       done,
  output logic       sign_err,
  output logic [1:0] state_dbg
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  state_e     state_q;
  logic [4:0] pattern_q;
  logic       busy_q, done_q, err_q;

  logic       xfer;
  logic [5:0] lut;
  logic       t_clear, t_load, t_zero;
  logic [CNT_W-1:0] t_load_val;

  // valid/ready: a sign is taken on the edge where sign_valid & sign_ready
  // are high and abort is low; abort in IDLE blocks the take while ready
  // stays high, so the producer keeps sign_valid asserted.
  assign sign_ready = (state_q == ST_IDLE);
  assign xfer       = sign_valid & sign_ready & ~abort;
  assign lut        = sign_to_pattern(sign_value);

  always_comb begin
    t_clear    = 1'b0;
    t_load     = 1'b0;
    t_load_val = HOLD_LOAD;
    case (state_q)
      ST_IDLE: t_load = xfer & lut[5];
      ST_HOLD: begin
        if (abort)
          t_clear = 1'b1;
        else if (t_zero && HAS_GAP) begin
          t_load     = 1'b1;
          t_load_val = GAP_LOAD;
        end
      end
      ST_GAP:  t_clear = abort;
      default: t_clear = 1'b1;
    endcase
  end

  hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst),
    .clear_i    (t_clear),
    .load_i     (t_load),
    .load_val_i (t_load_val),
    .zero_o     (t_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            if (lut[5]) begin
              state_q   <= ST_HOLD;
              pattern_q <= lut[4:0];
              busy_q    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            busy_q    <= 1'b0;
          end else if (t_zero) begin
            pattern_q <= '0;
            if (HAS_GAP) begin
              state_q <= ST_GAP;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (t_zero) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pattern_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign thumb_status  = pattern_q[4];
  assign index_status  = pattern_q[3];
  assign middle_status = pattern_q[2];
  assign ring_status   = pattern_q[1];
  assign pinky_status  = pattern_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign sign_err      = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sign_to_fingers.sv
// Bench for sign_to_fingers: default build (16/4) plus a HOLD=1, GAP=0 build.
module tb_sign_to_fingers;

  localparam int H = 16;
  localparam int G = 4;
  // Observation vector: {fingers[4:0], ready, busy, done, err}
  localparam logic [8:0] IDLE_V = 9'b00000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       sign_valid = 1'b0, abort = 1'b0;
  logic [3:0] sign_value = 4'd0;
  logic       sign_ready, thumb, index_f, middle, ring, pinky, busy, done, sign_err;
  logic [1:0] state_dbg;

  logic       v0 = 1'b0, a0 = 1'b0;
  logic [3:0] val0 = 4'd0;
  logic       r0, th0, in0, mi0, ri0, pi0, b0, d0, e0;
  logic [1:0] s0;

  int checks = 0;
  int errors = 0;

  logic [4:0] ref_tab [0:9] = '{5'b00000, 5'b01000, 5'b01100, 5'b01110, 5'b01111,
                                5'b11111, 5'b10000, 5'b10001, 5'b01001, 5'b11000};

  sign_to_fingers #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sign_valid(sign_valid), .sign_ready(sign_ready),
    .sign_value(sign_value), .abort(abort), .thumb_status(thumb),
    .index_status(index_f), .middle_status(middle), .ring_status(ring),
    .pinky_status(pinky), .busy(busy), .done(done), .sign_err(sign_err),
    .state_dbg(state_dbg)
  );

  sign_to_fingers #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .sign_valid(v0), .sign_ready(r0),
    .sign_value(val0), .abort(a0), .thumb_status(th0),
    .index_status(in0), .middle_status(mi0), .ring_status(ri0),
    .pinky_status(pi0), .busy(b0), .done(d0), .sign_err(e0),
    .state_dbg(s0)
  );

  function automatic logic [8:0] obs();
    return {thumb, index_f, middle, ring, pinky, sign_ready, busy, done, sign_err};
  endfunction

  function automatic logic [8:0] obs0();
    return {th0, in0, mi0, ri0, pi0, r0, b0, d0, e0};
  endfunction

  // Expected outputs t cycles after a sign is taken, from the playback rules.
  function automatic logic [8:0] exp_at(int code, int t, int hold, int gap);
    if (code > 9) return (t == 1) ? 9'b00000_1001 : IDLE_V;
    if (t <= hold) return {ref_tab[code], 4'b0100};
    if (t <= hold + gap) return 9'b00000_0100;
    if (t == hold + gap + 1) return 9'b00000_1010;
    return IDLE_V;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL reset_held got=%b exp=%b", obs(), IDLE_V);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    checks++;
    if (obs() !== IDLE_V || obs0() !== IDLE_V) begin
      errors++;
      $display("FAIL reset_release got=%b/%b exp=%b", obs(), obs0(), IDLE_V);
    end
  endtask

  task automatic test_sign3();
    sign_valid = 1'b1; sign_value = 4'd3;
    for (int t = 1; t <= H + G + 1; t++) begin
      step();
      if (t == 1) sign_valid = 1'b0;
      checks++;
      if (obs() !== exp_at(3, t, H, G)) begin
        errors++;
        $display("FAIL sign3 t=%0d got=%b exp=%b", t, obs(), exp_at(3, t, H, G));
      end
    end
    step();
    checks++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL sign3_after got=%b exp=%b", obs(), IDLE_V);
    end
  endtask

  task automatic test_undefined();
    sign_valid = 1'b1; sign_value = 4'd12;
    step();
    sign_valid = 1'b0;
    checks++;
    if (obs() !== 9'b00000_1001) begin
      errors++;
      $display("FAIL undef_err got=%b exp=%b", obs(), 9'b00000_1001);
    end
    step();
    checks++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL undef_after got=%b exp=%b", obs(), IDLE_V);
    end
    sign_valid = 1'b1; sign_value = 4'd5;
    for (int t = 1; t <= H + G + 1; t++) begin
      step();
      if (t == 1) sign_valid = 1'b0;
      checks++;
      if (obs() !== exp_at(5, t, H, G)) begin
        errors++;
        $display("FAIL sign5 t=%0d got=%b exp=%b", t, obs(), exp_at(5, t, H, G));
      end
    end
  endtask

  task automatic test_back_to_back();
    sign_valid = 1'b1; sign_value = 4'd7;
    for (int t = 1; t <= H + G + 1; t++) begin
      step();
      if (t == 1) sign_value = 4'd8;
      checks++;
      if (obs() !== exp_at(7, t, H, G)) begin
        errors++;
        $display("FAIL b2b_7 t=%0d got=%b exp=%b", t, obs(), exp_at(7, t, H, G));
      end
    end
    for (int t = 1; t <= H + G + 1; t++) begin
      step();
      if (t == 1) sign_valid = 1'b0;
      checks++;
      if (obs() !== exp_at(8, t, H, G)) begin
        errors++;
        $display("FAIL b2b_8 t=%0d got=%b exp=%b", t, obs(), exp_at(8, t, H, G));
      end
    end
  endtask

  task automatic test_abort();
    sign_valid = 1'b1; sign_value = 4'd9;
    for (int t = 1; t <= 5; t++) begin
      step();
      if (t == 1) sign_valid = 1'b0;
      checks++;
      if (obs() !== exp_at(9, t, H, G)) begin
        errors++;
        $display("FAIL abort_hold t=%0d got=%b exp=%b", t, obs(), exp_at(9, t, H, G));
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (obs() !== IDLE_V) begin
        errors++;
        $display("FAIL abort_idle t=%0d got=%b exp=%b", t, obs(), IDLE_V);
      end
      step();
    end
    sign_valid = 1'b1; sign_value = 4'd1; abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL abort_xfer got=%b exp=%b", obs(), IDLE_V);
    end
    for (int t = 1; t <= H + G + 1; t++) begin
      step();
      if (t == 1) sign_valid = 1'b0;
      checks++;
      if (obs() !== exp_at(1, t, H, G)) begin
        errors++;
        $display("FAIL abort_retry t=%0d got=%b exp=%b", t, obs(), exp_at(1, t, H, G));
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    sign_valid = 1'b1; sign_value = 4'd4;
    for (int t = 1; t <= 6; t++) begin
      step();
      if (t == 1) sign_valid = 1'b0;
      checks++;
      if (obs() !== exp_at(4, t, H, G)) begin
        errors++;
        $display("FAIL rst_hold t=%0d got=%b exp=%b", t, obs(), exp_at(4, t, H, G));
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL rst_async got=%b exp=%b", obs(), IDLE_V);
    end
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      checks++;
      if (obs() !== IDLE_V) begin
        errors++;
        $display("FAIL rst_after t=%0d got=%b exp=%b", t, obs(), IDLE_V);
      end
    end
  endtask

  task automatic test_gap0();
    v0 = 1'b1; val0 = 4'd2;
    for (int t = 1; t <= 3; t++) begin
      step();
      if (t == 1) v0 = 1'b0;
      checks++;
      if (obs0() !== exp_at(2, t, 1, 0)) begin
        errors++;
        $display("FAIL gap0 t=%0d got=%b exp=%b", t, obs0(), exp_at(2, t, 1, 0));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int code, idle, abort_t, len;
      code    = $urandom_range(0, 15);
      idle    = $urandom_range(0, 2);
      abort_t = ($urandom_range(0, 3) == 0) ? $urandom_range(1, H + G) : 0;
      for (int i = 0; i < idle; i++) begin
        step();
        checks++;
        if (obs() !== IDLE_V) begin
          errors++;
          $display("FAIL rand_idle n=%0d got=%b exp=%b", n, obs(), IDLE_V);
        end
      end
      sign_valid = 1'b1; sign_value = code[3:0];
      len = (code > 9) ? 1 : H + G + 1;
      for (int t = 1; t <= len; t++) begin
        step();
        if (t == 1) sign_valid = 1'b0;
        sign_value = 4'($urandom_range(0, 15));
        checks++;
        if (obs() !== exp_at(code, t, H, G)) begin
          errors++;
          $display("FAIL rand code=%0d t=%0d got=%b exp=%b", code, t, obs(), exp_at(code, t, H, G));
        end
        if (code <= 9 && t == abort_t) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          checks++;
          if (obs() !== IDLE_V) begin
            errors++;
            $display("FAIL rand_abort code=%0d t=%0d got=%b exp=%b", code, t, obs(), IDLE_V);
          end
          break;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sign3();
    test_undefined();
    test_back_to_back();
    test_abort();
    test_reset_mid_hold();
    test_gap0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
